// File: rtl/buffer_ra_instant.sv
// -----------------------------------------------------------------------------
// buffer_ra_instant
//
// Shift-in buffer with an "instant" read-ahead view. The stored buffer is
// combined with the chunk currently on data_in so the consumer sees the
// would-be result of the next shift without waiting for a clock edge. A
// trigger commits that view into storage.
//
// Parameters
//   BUFFER_SIZE : width of the stored buffer and of data_out (>= INPUT_SIZE)
//   INPUT_SIZE  : width of one input chunk (>= 1)
//   REVERSE     : 0 = new chunk enters at the LSB end,
//                 1 = new chunk enters at the MSB end
//
// Ports
//   clk_in   : clock, all state changes on its rising edge
//   rst_in   : asynchronous active-low reset, clears the stored buffer
//   data_in  : chunk to append (INPUT_SIZE bits)
//   trigger  : level-sampled commit; each rising edge with trigger high
//              loads the current data_out into the buffer
//   data_out : combinational view = stored buffer shifted by one chunk with
//              data_in appended (BUFFER_SIZE bits)
// -----------------------------------------------------------------------------
module buffer_ra_instant #(
   parameter int BUFFER_SIZE = 8,
   parameter int INPUT_SIZE  = 2,
   parameter int REVERSE     = 0
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [INPUT_SIZE-1:0]  data_in,
   input  logic                   trigger,
   output logic [BUFFER_SIZE-1:0] data_out
);

   generate
      if (INPUT_SIZE < 1 || BUFFER_SIZE < INPUT_SIZE ||
          (REVERSE != 0 && REVERSE != 1)) begin : g_bad_params
         $error("buffer_ra_instant: illegal parameters BUFFER_SIZE=%0d INPUT_SIZE=%0d REVERSE=%0d",
                BUFFER_SIZE, INPUT_SIZE, REVERSE);
      end
   endgenerate

   // Stored buffer. Named buf_r because "buf" is a reserved gate keyword.
   logic [BUFFER_SIZE-1:0] buf_r;

   // The chunk at the far end of buf_r never reaches data_out: it is the part
   // that falls off on the next commit. This reduction just marks it as
   // deliberately unread.
   logic unused_far_end;
   assign unused_far_end = ^buf_r;

   // Read-ahead view. When the buffer holds exactly one chunk there is nothing
   // left of the old contents after a shift, so the view is data_in alone.
   generate
      if (BUFFER_SIZE == INPUT_SIZE) begin : g_single_chunk
         assign data_out = data_in;
      end else if (REVERSE == 0) begin : g_shift_lsb
         assign data_out = {buf_r[BUFFER_SIZE-INPUT_SIZE-1:0], data_in};
      end else begin : g_shift_msb
         assign data_out = {data_in, buf_r[BUFFER_SIZE-1:INPUT_SIZE]};
      end
   endgenerate

   // Commit: the stored value after an edge is exactly what data_out showed
   // before it, so a committed chunk stays visible twice until data_in moves.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         buf_r <= '0;
      end else if (trigger) begin
         buf_r <= data_out;
      end
   end

endmodule

// File: tb/tb_buffer_ra_instant.sv
module tb_buffer_ra_instant;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       trigger;
   logic [1:0] di;
   logic [7:0] out_nor;
   logic [7:0] out_rev;
   logic [1:0] out_eq;

   always #5 clk = ~clk;

   buffer_ra_instant #(.BUFFER_SIZE(8), .INPUT_SIZE(2), .REVERSE(0)) u_nor (
      .clk_in(clk), .rst_in(rst_n), .data_in(di), .trigger(trigger), .data_out(out_nor));

   buffer_ra_instant #(.BUFFER_SIZE(8), .INPUT_SIZE(2), .REVERSE(1)) u_rev (
      .clk_in(clk), .rst_in(rst_n), .data_in(di), .trigger(trigger), .data_out(out_rev));

   buffer_ra_instant #(.BUFFER_SIZE(2), .INPUT_SIZE(2), .REVERSE(1)) u_eq (
      .clk_in(clk), .rst_in(rst_n), .data_in(di), .trigger(trigger), .data_out(out_eq));

   typedef struct {
      string      name;
      logic [7:0] en;
      logic [7:0] er;
      logic [1:0] ee;
   } exp_t;

   typedef struct {
      logic       trig;
      logic [1:0] di;
      logic [7:0] en;
      logic [7:0] er;
   } vec_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic push_exp(input string nm, input logic [7:0] en, input logic [7:0] er,
                           input logic [1:0] ee);
      exp_t e;
      e.name = nm;
      e.en   = en;
      e.er   = er;
      e.ee   = ee;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty: no expected entry for observed output");
      end else begin
         e = sb.pop_front();
         checks++;
         if (out_nor !== e.en) begin
            failures++;
            $display("FAIL %s nor: got %b expected %b", e.name, out_nor, e.en);
         end
         checks++;
         if (out_rev !== e.er) begin
            failures++;
            $display("FAIL %s rev: got %b expected %b", e.name, out_rev, e.er);
         end
         checks++;
         if (out_eq !== e.ee) begin
            failures++;
            $display("FAIL %s eq: got %b expected %b", e.name, out_eq, e.ee);
         end
      end
   endtask

   // Expected results go into the scoreboard as the stimulus is applied; the
   // combinational outputs are then sampled 1 time unit later.
   task automatic settle_check(input string nm, input logic [7:0] en, input logic [7:0] er);
      push_exp(nm, en, er, di);
      #1;
      compare_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt[11];
      logic [1:0] r;

      vt[0]  = '{1'b0, 2'b00, 8'b00000000, 8'b00000000};
      vt[1]  = '{1'b0, 2'b01, 8'b00000001, 8'b01000000};
      vt[2]  = '{1'b1, 2'b01, 8'b00000101, 8'b01010000};
      vt[3]  = '{1'b0, 2'b10, 8'b00000110, 8'b10010000};
      vt[4]  = '{1'b1, 2'b10, 8'b00011010, 8'b10100100};
      vt[5]  = '{1'b0, 2'b11, 8'b00011011, 8'b11100100};
      vt[6]  = '{1'b1, 2'b11, 8'b01101111, 8'b11111001};
      vt[7]  = '{1'b0, 2'b00, 8'b01101100, 8'b00111001};
      vt[8]  = '{1'b1, 2'b00, 8'b10110000, 8'b00001110};
      vt[9]  = '{1'b0, 2'b01, 8'b10110001, 8'b01001110};
      vt[10] = '{1'b1, 2'b01, 8'b11000101, 8'b01010011};

      // Reset state: buffer zero, data_in still visible, trigger ignored.
      rst_n   = 1'b0;
      trigger = 1'b0;
      di      = 2'b00;
      #2;
      settle_check("reset_zero", 8'b00000000, 8'b00000000);
      di = 2'b10;
      settle_check("reset_view", 8'b00000010, 8'b10000000);
      @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      settle_check("reset_trig_ignored", 8'b00000010, 8'b10000000);
      @(negedge clk);
      rst_n = 1'b1;
      di    = 2'b00;

      // Table-driven main sequence, including overflow/discard.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         di = vt[i].di;
         if (vt[i].trig) begin
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
         end
         settle_check($sformatf("vec%0d", i), vt[i].en, vt[i].er);
      end

      // Asynchronous reset mid-cycle discards stored chunks.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      settle_check("async_rst_clear", {6'b000000, di}, {di, 6'b000000});
      @(negedge clk);
      rst_n = 1'b1;

      // Trigger held high for three edges with data_in=11.
      @(negedge clk);
      di      = 2'b11;
      trigger = 1'b1;
      @(negedge clk);
      settle_check("hold_edge1", 8'b00001111, 8'b11110000);
      @(negedge clk);
      settle_check("hold_edge2", 8'b00111111, 8'b11111100);
      @(negedge clk);
      trigger = 1'b0;
      settle_check("hold_edge3", 8'b11111111, 8'b11111111);

      // Reset asserted mid-cycle, away from any edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      settle_check("midcycle_rst", 8'b00000011, 8'b11000000);
      @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      settle_check("rst_low_trig", 8'b00000011, 8'b11000000);
      @(negedge clk);
      rst_n = 1'b1;
      settle_check("rst_release", 8'b00000011, 8'b11000000);

      // First shift after release.
      @(negedge clk);
      di      = 2'b01;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      settle_check("first_shift", 8'b00000101, 8'b01010000);

      // trigger low, data_in toggling: buffer holds, only the chunk moves.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         r  = 2'($urandom_range(0, 3));
         di = r;
         settle_check($sformatf("hold%0d", k), {6'b000001, r}, {r, 6'b010000});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
